pwm_ddpm_multi: RTL and testbench

Multi-channel, width-parametrised successor of the single-channel PWM/DDPM generator. Each channel drives one output bit. Per channel, that bit is either a PWM waveform or a first-order delta-density (DDPM) bitstream; the choice is made at runtime. Duty/mode updates arrive over a valid/ready write port and are double-buffered, so they only take effect on a period boundary. The top-level pin wrapper instantiates it with CHANNELS=2 and WIDTH=6.

---
 rtl/pwm_ddpm_multi.sv | 179 +++++++++++++++++
 tb/tb_pwm_ddpm_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ddpm_multi.sv
// pwm_ddpm_multi: multi-channel PWM / first-order delta-density modulator.
//
// One shared period counter drives CHANNELS independent outputs. Each channel
// is either PWM (out = cnt < duty) or DDPM (out = carry of acc + duty), chosen
// at runtime. Duty/mode writes are double-buffered: a write lands in a
// per-channel pending slot and is copied to the active slot on the next
// period boundary (or on any cycle while enable=0).
//
// Build option CENTER_ALIGN_EN: when defined, the counter runs as a triangle
// (0 -> 2^WIDTH-1 -> 0) giving centre-aligned PWM with a period of
// 2*(2^WIDTH-1) cycles. When undefined, the counter is edge-aligned
// (0 -> 2^WIDTH-1, wrap) with a period of 2^WIDTH cycles.
//
// Write handshake: a write transfers on any rising clk edge where
// wr_valid && wr_ready. wr_ready is combinational and equals the inverse of
// the addressed channel's pending flag (1 for channel numbers >= CHANNELS,
// whose writes are accepted and dropped). wr_valid may be raised at any time
// and the payload must be held stable while wr_valid=1 and wr_ready=0.

module pwm_ddpm_multi #(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 2,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CHW-1:0]      wr_chan,
    input  logic                wr_mode,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] out,
    output logic                period_start
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0]    cnt;
    logic                boundary;
    logic                xfer;
    logic [CHANNELS-1:0] pend_flags;

`ifdef CENTER_ALIGN_EN
    logic cnt_down;

    // Last cycle of a triangle period: counting down with cnt==1.
    assign boundary = enable && cnt_down && (cnt == CNT_ONE);

    // Triangle counter: up to CNT_MAX, then down to 0; held at 0/up when idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            cnt_down <= 1'b0;
        end else if (!enable) begin
            cnt      <= '0;
            cnt_down <= 1'b0;
        end else if (!cnt_down) begin
            if (cnt == CNT_MAX) begin
                cnt      <= cnt - CNT_ONE;
                cnt_down <= 1'b1;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end else begin
            if (cnt == CNT_ONE) begin
                cnt_down <= 1'b0;
            end
            cnt <= cnt - CNT_ONE;
        end
    end
`else
    // Last cycle of an edge-aligned period: cnt at its maximum.
    assign boundary = enable && (cnt == CNT_MAX);

    // Edge-aligned counter: free-running wrap while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end
`endif

    // Pending values move to active on a boundary, or every cycle while idle.
    assign xfer = !enable || boundary;

    // Ready mirrors the addressed channel's free pending slot; unknown channels always ready.
    always_comb begin
        wr_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_chan == CHW'(i)) begin
                wr_ready = ~pend_flags[i];
            end
        end
    end

    // Period-start pulse lands in the cycle where cnt has returned to 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic             pend_valid;
        logic             pend_mode;
        logic [WIDTH-1:0] pend_duty;
        logic             act_mode;
        logic [WIDTH-1:0] act_duty;
        logic [WIDTH-1:0] acc;
        logic [WIDTH:0]   sum;
        logic             wr_hit;
        logic             do_xfer;
        logic             mode_change;
        logic             out_q;

        assign wr_hit      = wr_valid && wr_ready && (wr_chan == CHW'(i));
        assign do_xfer     = xfer && pend_valid;
        assign mode_change = do_xfer && (pend_mode != act_mode);
        assign sum         = {1'b0, acc} + {1'b0, act_duty};

        assign pend_flags[i] = pend_valid;
        assign out[i]        = out_q;

        // Double buffer: transfer old pending first, then a same-cycle write refills it.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                pend_valid <= 1'b0;
                pend_mode  <= 1'b0;
                pend_duty  <= '0;
                act_mode   <= 1'b0;
                act_duty   <= '0;
            end else begin
                if (do_xfer) begin
                    act_mode   <= pend_mode;
                    act_duty   <= pend_duty;
                    pend_valid <= 1'b0;
                end
                if (wr_hit) begin
                    pend_mode  <= wr_mode;
                    pend_duty  <= wr_data;
                    pend_valid <= 1'b1;
                end
            end
        end

        // Accumulator advances only in DDPM; a mode switch restarts it from 0.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                acc <= '0;
            end else if (mode_change) begin
                acc <= '0;
            end else if (enable && act_mode) begin
                acc <= sum[WIDTH-1:0];
            end
        end

        // Registered output: compare for PWM, accumulator carry for DDPM, 0 when idle.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                out_q <= 1'b0;
            end else if (!enable) begin
                out_q <= 1'b0;
            end else if (act_mode) begin
                out_q <= sum[WIDTH];
            end else begin
                out_q <= (cnt < act_duty);
            end
        end
    end

endmodule

// File: tb/tb_pwm_ddpm_multi.sv
// Directed bench for pwm_ddpm_multi (WIDTH=6, CHANNELS=2).
// Build option CENTER_ALIGN_EN selects the centre-aligned scenario.
// Cycle index k counts rising edges since enable went high; outputs are
// sampled 1 ns after each edge. With cnt=0 before edge 1, the registered
// outputs seen after edge k were computed from the counter value after k-1 edges.

module tb_pwm_ddpm_multi;

  localparam int WIDTH    = 6;
  localparam int CHANNELS = 2;
  localparam int CHW      = 1;
`ifdef CENTER_ALIGN_EN
  localparam int PERIOD = 126;
`else
  localparam int PERIOD = 64;
`endif

  logic                clk      = 1'b0;
  logic                resetn   = 1'b0;
  logic                enable   = 1'b0;
  logic                wr_valid = 1'b0;
  logic                wr_mode  = 1'b0;
  logic [CHW-1:0]      wr_chan  = '0;
  logic [WIDTH-1:0]    wr_data  = '0;
  logic                wr_ready;
  logic                period_start;
  logic [CHANNELS-1:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  pwm_ddpm_multi #(
    .WIDTH(WIDTH),
    .CHANNELS(CHANNELS)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_chan(wr_chan),
    .wr_mode(wr_mode),
    .wr_data(wr_data),
    .out(out),
    .period_start(period_start)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int chan, input logic mode, input int data);
    wr_chan  = CHW'(chan);
    wr_mode  = mode;
    wr_data  = WIDTH'(data);
    wr_valid = 1'b1;
  endtask

  // Write while enable=0: accepted on one edge, made active on the next.
  task automatic write_idle(input int chan, input logic mode, input int data);
    drive_wr(chan, mode, data);
    #1;
    check($sformatf("idle_ready ch%0d", chan), wr_ready, 1);
    step();
    wr_valid = 1'b0;
    step();
  endtask

  function automatic logic pwm_exp(input int k, input int duty);
    return ((k - 1) % 64) < duty;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e0, e1;
    int   highs;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 0);
    check("reset_ps", period_start, 0);
    resetn = 1'b1;
    #1;
    check("reset_ready", wr_ready, 1);

`ifdef CENTER_ALIGN_EN
    write_idle(0, 1'b0, 10);
    enable = 1'b1;
    highs  = 0;
    for (int k = 1; k <= 260; k++) begin
      int m;
      int c;
      step();
      m  = (k - 1) % 126;
      c  = (m <= 63) ? m : 126 - m;
      e0 = (c < 10);
      check($sformatf("c_out0 k=%0d", k), out[0], e0);
      check($sformatf("c_out1 k=%0d", k), out[1], 0);
      check($sformatf("c_ps k=%0d", k), period_start, (k % 126) == 0);
      if (k >= 127 && k <= 252 && out[0] === 1'b1) highs++;
    end
    // cnt==0 is visited once per period, cnt==1..9 twice each.
    check("center_pulse_len", highs, 19);
    enable = 1'b0;
`else
    write_idle(0, 1'b0, 16);
    write_idle(1, 1'b1, 32);
    enable = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      step();
      if (k <= 192)      e0 = pwm_exp(k, 16);
      else if (k <= 256) e0 = 1'b0;
      else if (k <= 320) e0 = pwm_exp(k, 63);
      else if (k <= 384) e0 = pwm_exp(k, 20);
      else               e0 = ((k - 384) % 8) == 0;
      e1 = (k <= 256) ? ((k % 2) == 0) : ((k % 4) == 0);
      check($sformatf("out0 k=%0d", k), out[0], e0);
      check($sformatf("out1 k=%0d", k), out[1], e1);
      check($sformatf("ps k=%0d", k), period_start, (k % 64) == 0);

      wr_valid = 1'b0;
      if (k == 130) begin
        drive_wr(0, 1'b0, 0);
        #1 check("bp_first_ready", wr_ready, 1);
      end else if (k >= 131 && k <= 191) begin
        drive_wr(0, 1'b0, 63);
        #1 check($sformatf("bp_stall k=%0d", k), wr_ready, 0);
      end else if (k == 192) begin
        drive_wr(0, 1'b0, 63);
        #1 check("bp_release", wr_ready, 1);
      end else if (k == 193) begin
        wr_chan = 1'b0;
        #1 check("bp_refilled", wr_ready, 0);
      end else if (k == 200) begin
        drive_wr(1, 1'b1, 16);
        #1 check("ch1_wr_ready", wr_ready, 1);
      end else if (k == 201) begin
        wr_chan = 1'b1;
        #1 check("ch1_pending", wr_ready, 0);
      end else if (k == 257) begin
        wr_chan = 1'b1;
        #1 check("ch1_drained", wr_ready, 1);
      end else if (k == 260) begin
        drive_wr(0, 1'b0, 20);
        #1 check("ch0_pwm20_ready", wr_ready, 1);
      end else if (k == 330) begin
        drive_wr(0, 1'b1, 8);
        #1 check("ch0_ddpm8_ready", wr_ready, 1);
      end
      if (k == 400) enable = 1'b0;
    end
`endif

    // enable=0 forces outputs low
    for (int j = 1; j <= 3; j++) begin
      step();
      check($sformatf("dis_out j=%0d", j), out, 0);
      check($sformatf("dis_ps j=%0d", j), period_start, 0);
    end

    // mid-run reset: pending write is lost, counter restarts at 0
    enable = 1'b1;
    drive_wr(0, 1'b0, 40);
    #1 check("pre_rst_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    #1 check("pre_rst_pending", wr_ready, 0);
    repeat (5) step();
    resetn = 1'b0;
    #1;
    check("rst_out", out, 0);
    check("rst_ps", period_start, 0);
    step();
    resetn = 1'b1;
    #1 check("post_rst_ready", wr_ready, 1);
    for (int r = 1; r <= PERIOD + 4; r++) begin
      step();
      check($sformatf("post_rst_ps r=%0d", r), period_start, r == PERIOD);
      check($sformatf("post_rst_out r=%0d", r), out, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
